// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder over valid/ready request and response channels
// Optional macro DMEM_RANGE_CHECK_EN: flag out-of-range addresses with rsp_err instead of wrapping.
module data_mem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            oor_q, oor_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2]};

  // reset gating keeps the request channel closed while reset is asserted
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
`ifdef DMEM_RANGE_CHECK_EN
          oor_d   = |req_addr[31:AW+2];
`else
          oor_d   = 1'b0;
`endif
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = oor_q;
          if (write_q) begin
            rdata_d = 32'h0;
            mem_we  = !oor_q;
          end else begin
            rdata_d = oor_q ? 32'h0 : mem[idx_q];
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      oor_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is never reset; a store pending when reset hits is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule
